// File: rtl/ap_output_collector_pkg.sv
// rtl/ap_output_collector_pkg.sv - shared widths, state encoding and lane helper
// Purpose: default parameters and the FSM state type for the output collector.
// Lane convention: core i occupies the MSB-first slice, i.e. core 0 is the top byte.
package ap_output_collector_pkg;

  localparam int OUTPORT_DEF = 8;
  localparam int N_CORE_DEF  = 8;
  localparam int ADDR_W_DEF  = 12;
  localparam int LEN_W_DEF   = 12;
  localparam int DEPTH_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // LSB position of core `lane` inside a packed lane vector (core 0 is the MSB slice).
  function automatic int lane_lsb(int lane, int lane_w, int n_lanes);
    return (n_lanes - 1 - lane) * lane_w;
  endfunction

endpackage

// File: rtl/ap_output_collector_if.sv
// rtl/ap_output_collector_if.sv - core-result capture bus and memory write port
// Purpose: groups the per-core inputs and the valid/ready write port.
// Signals: in_data/in_en (core results and strobes), wr_valid/wr_ready handshake,
//          wr_addr/wr_data/wr_mask (write request payload).
// master: collector side; slave: environment (cores + output memory).
interface ap_output_collector_if
  import ap_output_collector_pkg::*;
#(
  parameter int outport = OUTPORT_DEF,
  parameter int N_core  = N_CORE_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) ();

  logic [outport*N_core-1:0] in_data;
  logic [N_core-1:0]         in_en;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [outport*N_core-1:0] wr_data;
  logic [N_core-1:0]         wr_mask;

  modport master (
    input  in_data, in_en, wr_ready,
    output wr_valid, wr_addr, wr_data, wr_mask
  );

  modport slave (
    output in_data, in_en, wr_ready,
    input  wr_valid, wr_addr, wr_data, wr_mask
  );

endinterface

// File: rtl/ap_sync_fifo.sv
// rtl/ap_sync_fifo.sv - synchronous FIFO with registered storage head
// Purpose: buffers packed capture words between the cores and the write port.
// Ports: clk, reset (async active-low), push/push_data, pop, head (oldest entry),
//        full, empty. Push while full is accepted when a pop happens in the same cycle.
module ap_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the write port shows zeros afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ap_output_collector.sv
// rtl/ap_output_collector.sv - collects per-core results into output-memory writes
// Purpose: packs each strobe cycle into {masked data, lane mask}, buffers it and drains
//          it to the write port at an auto-incrementing address for one framed run.
// Ports: clk, reset (async active-low), start/cfg_base/cfg_len (run framing),
//        bus (master side of the capture/write interface), busy, done (1-cycle pulse),
//        overflow (sticky capture drop).
module ap_output_collector
  import ap_output_collector_pkg::*;
#(
  parameter int outport = OUTPORT_DEF,
  parameter int N_core  = N_CORE_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [LEN_W-1:0]   cfg_len,
  ap_output_collector_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int DW = outport * N_core;
  localparam int WW = DW + N_core;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  push_left_q;
  logic [LEN_W-1:0]  pop_left_q;
  logic              overflow_q;

  logic [DW-1:0]     masked;
  logic [WW-1:0]     fifo_head;
  logic              fifo_full, fifo_empty;
  logic              in_run, capture, push, drop, pop, accept_start;

  assign in_run       = (state_q == ST_RUN);
  assign accept_start = (state_q == ST_IDLE) && start;
  assign capture      = in_run && (|bus.in_en) && (push_left_q != '0);
  assign pop          = bus.wr_valid && bus.wr_ready;
  assign push         = capture && (!fifo_full || pop);
  assign drop         = capture && !push;

  // Lanes whose strobe is low are zeroed so stale core outputs never reach memory.
  always_comb begin
    masked = '0;
    for (int k = 0; k < N_core; k++) begin
      if (bus.in_en[N_core-1-k])
        masked[lane_lsb(k, outport, N_core) +: outport] = bus.in_data[lane_lsb(k, outport, N_core) +: outport];
    end
  end

  ap_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({masked, bus.in_en}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.wr_valid = in_run && !fifo_empty;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = fifo_head[WW-1:N_core];
  assign bus.wr_mask  = fifo_head[N_core-1:0];
  assign overflow     = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (pop && (pop_left_q == LEN_W'(1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      push_left_q <= '0;
      pop_left_q  <= '0;
      overflow_q  <= 1'b0;
    end else if (accept_start) begin
      addr_q      <= cfg_base;
      push_left_q <= cfg_len;
      pop_left_q  <= cfg_len;
      overflow_q  <= 1'b0;
    end else begin
      if (pop) begin
        addr_q     <= addr_q + ADDR_W'(1);
        pop_left_q <= pop_left_q - LEN_W'(1);
      end
      if (push) push_left_q <= push_left_q - LEN_W'(1);
      if (drop) overflow_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_output_collector.sv
// tb/tb_ap_output_collector.sv - scoreboard bench for ap_output_collector
module tb_ap_output_collector;

  localparam int W     = 8;
  localparam int N     = 8;
  localparam int AW    = 12;
  localparam int LW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy, done, overflow;

  ap_output_collector_if #(.outport(W), .N_core(N), .ADDR_W(AW)) bus ();

  ap_output_collector #(
    .outport (W),
    .N_core  (N),
    .ADDR_W  (AW),
    .LEN_W   (LW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_base (cfg_base),
    .cfg_len  (cfg_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Transaction-level reference: run phase (0 idle, 1 run, 2 done), words held, counters.
  int          ph = 0;
  int          fill = 0;
  int          m_push_left = 0;
  int          m_pop_left = 0;
  int          m_idx = 0;
  logic [11:0] m_base = '0;
  logic        m_ovf = 1'b0;

  function automatic logic [63:0] mask_lanes(logic [63:0] d, logic [7:0] en);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (en[7-i]) r[63-8*i -: 8] = d[63-8*i -: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any presented write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.wr_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        chk("wr_addr", 64'(bus.wr_addr), 64'(sb[0].addr));
        chk("wr_data", bus.wr_data, sb[0].data);
        chk("wr_mask", 64'(bus.wr_mask), 64'(sb[0].mask));
        if (bus.wr_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic st, input logic [11:0] base, input logic [11:0] len,
                      input logic [7:0] en, input logic [63:0] data, input logic rdy);
    logic pop, cap, acc;
    start       = st;
    cfg_base    = base;
    cfg_len     = len;
    bus.in_en   = en;
    bus.in_data = data;
    bus.wr_ready = rdy;
    pop = (ph == 1) && (fill > 0) && rdy;
    cap = (ph == 1) && (en != 0) && (m_push_left > 0);
    acc = cap && ((fill < DEPTH) || pop);
    if (acc) begin
      sb.push_back('{addr: m_base + 12'(m_idx), data: mask_lanes(data, en), mask: en});
      m_idx++;
      m_push_left--;
    end
    @(negedge clk);
    chk("wr_valid", 64'(bus.wr_valid), 64'((ph == 1) && (fill > 0)));
    chk("busy", 64'(busy), 64'(ph == 1));
    chk("done", 64'(done), 64'(ph == 2));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    @(posedge clk);
    fill = fill + int'(acc) - int'(pop);
    if (cap && !acc) m_ovf = 1'b1;
    case (ph)
      0: if (st) begin
        m_base = base; m_push_left = int'(len); m_pop_left = int'(len);
        m_idx = 0; m_ovf = 1'b0;
        ph = (len == 0) ? 2 : 1;
      end
      1: if (pop) begin
        m_pop_left--;
        if (m_pop_left == 0) ph = 2;
      end
      default: ph = 0;
    endcase
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    chk("rst_wr_mask", 64'(bus.wr_mask), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    sb.delete();
    ph = 0; fill = 0; m_ovf = 1'b0;
    start = 1'b0; bus.in_en = '0; bus.in_data = '0; bus.wr_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_out(input int max);
    int n;
    n = 0;
    while (ph != 0 && n < max) begin
      step(1'b0, 12'h0, 12'h0, 8'h00, 64'h0, 1'b1);
      n++;
    end
    checks++;
    if (ph != 0) begin
      errors++;
      $display("FAIL run_timeout: got still running after %0d cycles, expected idle", max);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic basic_run();
    step(1'b1, 12'h010, 12'd3, 8'h00, 64'h0, 1'b1);
    step(1'b0, 12'h0, 12'h0, 8'hFF, 64'h0102030405060708, 1'b1);
    step(1'b0, 12'h0, 12'h0, 8'hFF, 64'h1112131415161718, 1'b1);
    step(1'b0, 12'h0, 12'h0, 8'hFF, 64'h2122232425262728, 1'b1);
    run_out(20);
  endtask

  task automatic random_run();
    logic [7:0] en;
    logic       rdy;
    int         n;
    step(1'b1, 12'($urandom), 12'($urandom_range(1, 12)), 8'h00, 64'h0, 1'($urandom));
    n = 0;
    while (ph != 0 && n < 300) begin
      en  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      rdy = (fill >= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b0, 12'($urandom), 12'($urandom), en, {$urandom, $urandom}, rdy);
      n++;
    end
    run_out(40);
  endtask

  initial begin
    bus.in_en = '0;
    bus.in_data = '0;
    bus.wr_ready = 1'b0;
    do_reset();

    basic_run();

    step(1'b1, 12'h100, 12'd1, 8'h00, 64'h0, 1'b1);
    step(1'b0, 12'h0, 12'h0, 8'b1010_0000, {8{8'hAA}}, 1'b1);
    run_out(20);

    // Backpressure: eight stored, ninth dropped, then drain while the run stays open.
    step(1'b1, 12'h200, 12'd10, 8'h00, 64'h0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 12'h0, 12'h0, 8'hFF, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 12'h0, 8'h00, 64'h0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 12'h0, 12'h0, 8'h00, 64'h0, 1'b1);
    do_reset();

    // Full FIFO with a simultaneous pop accepts the capture.
    step(1'b1, 12'h300, 12'd9, 8'h00, 64'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 12'h0, 12'h0, 8'($urandom) | 8'h01, {$urandom, $urandom}, 1'b0);
    step(1'b0, 12'h0, 12'h0, 8'hC3, {$urandom, $urandom}, 1'b1);
    run_out(40);

    // Address wrap.
    step(1'b1, 12'hFFF, 12'd2, 8'h00, 64'h0, 1'b1);
    step(1'b0, 12'h0, 12'h0, 8'h0F, 64'hDEADBEEFCAFEF00D, 1'b1);
    step(1'b0, 12'h0, 12'h0, 8'hF0, 64'h0123456789ABCDEF, 1'b1);
    run_out(20);

    // Zero-length run.
    step(1'b1, 12'h050, 12'd0, 8'hFF, 64'h55, 1'b1);
    run_out(5);

    // Start during a run is ignored.
    step(1'b1, 12'h400, 12'd2, 8'h00, 64'h0, 1'b0);
    step(1'b0, 12'h0, 12'h0, 8'h81, 64'hA1A2A3A4A5A6A7A8, 1'b0);
    step(1'b1, 12'h7AA, 12'd5, 8'h18, 64'hB1B2B3B4B5B6B7B8, 1'b1);
    run_out(20);

    // Strobes while idle produce no writes.
    for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 12'h0, 8'hFF, {$urandom, $urandom}, 1'b1);

    // Reset with entries queued, then a fresh run.
    step(1'b1, 12'h500, 12'd5, 8'h00, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 12'h0, 8'hFF, {$urandom, $urandom}, 1'b0);
    do_reset();
    basic_run();

    for (int r = 0; r < 20; r++) random_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_output_collector.md
Name: ap_output_collector

Overview:
- Downstream stage of the arithmetic part. Consumes the N_core per-core result bytes and per-core out_en strobes.
- Packs each strobe cycle into one wide word (data plus lane mask) and buffers it in a FIFO.
- Drains the FIFO to an output-memory write port with a valid/ready handshake and an auto-incrementing address.
- One collection run is framed by start/cfg_len and ends with a done pulse.

Parameters:
- outport, 8, bits per core result lane
- N_core, 8, number of lanes (arithmetic cores)
- ADDR_W, 12, write-address width
- LEN_W, 12, width of the word-count configuration
- DEPTH, 8, FIFO entries (power of two, >=2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_data  input  outport*N_core  core results; core i at [outport*N_core-i*outport-1 -: outport]
- in_en  input  N_core  per-core valid; core i at bit N_core-1-i
- start  input  1  one-cycle pulse; begins a run
- cfg_base  input  ADDR_W  first write address, sampled on start
- cfg_len  input  LEN_W  number of words in the run, sampled on start
- wr_valid  output  1  write request
- wr_ready  input  1  memory accepts the write
- wr_addr  output  ADDR_W  write address
- wr_data  output  outport*N_core  packed word, same lane order as in_data
- wr_mask  output  N_core  byte-lane enables, same order as in_en
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at end of run
- overflow  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; FIFO empty; all counters 0; wr_valid, wr_addr, wr_data, wr_mask, busy, done, overflow all 0.
- States:
  - IDLE: start -> RUN, or DONE if cfg_len==0.
    - On start: addr<=cfg_base, push_left<=cfg_len, pop_left<=cfg_len, overflow<=0.
  - RUN: busy=1. Goes to DONE on the cycle after the last pop handshake (pop_left reaches 0).
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored outside IDLE.
- Capture (RUN only):
  - A cycle is a capture when |in_en && push_left!=0.
  - Entry = {in_data with lanes whose in_en bit is 0 forced to 0, in_en}.
  - If FIFO not full, or a pop occurs in the same cycle: push, push_left-1.
  - Else: drop, overflow<=1, push_left unchanged.
- in_en is ignored in IDLE, in DONE, and once push_left==0. These are not overflows.
- Drain:
  - wr_valid = FIFO non-empty in RUN; wr_data/wr_mask = FIFO head; wr_addr = addr.
  - Pop on wr_valid && wr_ready: addr<=addr+1 (wraps modulo 2^ADDR_W), pop_left-1.
  - While wr_valid=1 and wr_ready=0, wr_addr/wr_data/wr_mask hold stable.
- Latency: a capture in cycle t into an empty FIFO gives wr_valid=1 in cycle t+1. Throughput is 1 word/cycle with wr_ready held high.
- Push and pop in the same cycle:
  - Allowed at any fill level, including full (count unchanged).
  - When empty, the push is not bypassed (head appears next cycle).
- overflow holds until the next accepted start or reset. With drops, pop_left never reaches 0; software aborts via reset.
- Reset mid-run: immediate return to reset state; FIFO contents discarded.

Decomposition:
- Shared package holds:
  - default widths (outport, N_core, ADDR_W, LEN_W, DEPTH)
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - a lane-slice helper convention (core i = MSB-first slice)
- One sub-module: ap_sync_fifo.
  - Parameterised width/depth; registered head output; full/empty/count.
  - Simultaneous push and pop is legal when full.
- The collector holds the FSM, counters, masking and overflow.

Test Plan:
1. Basic run: start, cfg_base=0x010, cfg_len=3; in_en=8'hFF three consecutive cycles with data 0x0102..08, 0x1112..18, 0x2122..28; wr_ready=1 -> writes at 0x010, 0x011, 0x012 with mask FF, first wr_valid one cycle after first capture; done pulses once, busy falls.
2. Partial mask: in_en=8'b1010_0000, in_data all lanes 0xAA -> wr_data=0xAA00AA00_00000000, wr_mask=8'hA0.
3. Backpressure/overflow: DEPTH=8, cfg_len=10, wr_ready=0, 9 capture cycles -> first 8 stored, 9th dropped, overflow=1; wr_data stable while stalled; raising wr_ready drains 8 words in order.
4. Full with simultaneous pop: fill FIFO, then capture with wr_ready=1 in the same cycle -> capture accepted, no overflow, count stays 8.
5. Edges: cfg_base=0xFFF, cfg_len=2 -> addresses 0xFFF then 0x000. cfg_len=0 -> done the cycle after start, no writes. start during RUN ignored. in_en while IDLE -> no write.
6. Async reset asserted mid-run with 3 entries queued -> outputs 0 immediately; after release, a new run behaves as scenario 1.
